board_ctrl_sequencer: RTL and testbench

BOARD_CTRL_SEQUENCER -- requirements
Module: board_ctrl_sequencer

---
 rtl/board_ctrl_sequencer_if.sv | 24 ++
 rtl/board_ctrl_sequencer.sv | 154 +++++++++++++++
 tb/tb_board_ctrl_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_ctrl_sequencer_if.sv
// Board control sequencer I/O bundle.
// Raw board inputs in, core reset/inputs/status out.
interface board_ctrl_sequencer_if;
  logic       pll_locked;
  logic       btn_rst_n;
  logic [2:0] btn;
  logic       core_rst_n;
  logic [6:0] ui_in;
  logic [2:0] btn_db;
  logic       heartbeat;
  logic [1:0] state;

  modport master (
    output pll_locked, btn_rst_n, btn,
    input  core_rst_n, ui_in, btn_db,
    input  heartbeat, state
  );

  modport slave (
    input  pll_locked, btn_rst_n, btn,
    output core_rst_n, ui_in, btn_db,
    output heartbeat, state
  );
endinterface

// File: rtl/board_ctrl_sequencer.sv
// Board control sequencer: input sync/debounce,
// core reset sequencing and heartbeat LED.
module board_ctrl_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 250000,
  parameter int unsigned RESET_HOLD_CYCLES = 1024,
  parameter int unsigned HEARTBEAT_CYCLES  = 25200000
) (
  input logic                   clk,
  input logic                   rst,
  board_ctrl_sequencer_if.slave bus
);
  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
  localparam int unsigned HW = $clog2(RESET_HOLD_CYCLES);
  localparam int unsigned BW = $clog2(HEARTBEAT_CYCLES);
  localparam logic [DW-1:0] DB_LAST =
    DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST =
    HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [BW-1:0] HB_LAST =
    BW'(HEARTBEAT_CYCLES - 1);
  // bit 3 is the active-low reset button: idles high
  localparam logic [3:0] BTN_IDLE = 4'b1000;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RUN       = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic                   lk1_q, lk1_d;
  logic                   lk2_q, lk2_d;
  logic [3:0]             s1_q, s1_d;
  logic [3:0]             s2_q, s2_d;
  logic [3:0]             db_q, db_d;
  logic [3:0][DW-1:0]     dbc_q, dbc_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [BW-1:0]          hb_cnt_q, hb_cnt_d;
  logic                   hb_q, hb_d;
  logic                   lock;
  logic                   rst_pressed;
  logic                   run;

  assign lock        = lk2_q;
  assign rst_pressed = ~db_q[3];
  assign run         = (state_q == RUN);

  // two-flop synchronizers for all raw inputs
  always_comb begin
    lk1_d = bus.pll_locked;
    lk2_d = lk1_q;
    s1_d  = {bus.btn_rst_n, bus.btn};
    s2_d  = s1_q;
  end

  // per-input debounce counters on synced levels
  always_comb begin
    db_d  = db_q;
    dbc_d = dbc_q;
    for (int i = 0; i < 4; i++) begin
      if (s2_q[i] == db_q[i]) begin
        dbc_d[i] = '0;
      end else if (dbc_q[i] == DB_LAST) begin
        db_d[i]  = s2_q[i];
        dbc_d[i] = '0;
      end else begin
        dbc_d[i] = dbc_q[i] + DW'(1);
      end
    end
  end

  // sequencer: lock loss beats button reset
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock) state_d = HOLD;
      end
      HOLD: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
        end else if (rst_pressed) begin
          hold_d = '0;
        end else if (hold_q == HOLD_LAST) begin
          state_d = RUN;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      RUN: begin
        if (!lock) begin
          state_d = WAIT_LOCK;
        end else if (rst_pressed) begin
          state_d = HOLD;
        end
      end
      default: state_d = WAIT_LOCK;
    endcase
    // every HOLD visit starts from a cleared count
    if (state_d != HOLD || state_q != HOLD) begin
      hold_d = '0;
    end
  end

  // heartbeat runs only while staying in RUN
  always_comb begin
    hb_cnt_d = '0;
    hb_d     = hb_q;
    if (run && state_d == RUN) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_d = ~hb_q;
      end else begin
        hb_cnt_d = hb_cnt_q + BW'(1);
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      lk1_q    <= 1'b0;
      lk2_q    <= 1'b0;
      s1_q     <= BTN_IDLE;
      s2_q     <= BTN_IDLE;
      db_q     <= BTN_IDLE;
      dbc_q    <= '0;
      hold_q   <= '0;
      hb_cnt_q <= '0;
      hb_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      lk1_q    <= lk1_d;
      lk2_q    <= lk2_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      db_q     <= db_d;
      dbc_q    <= dbc_d;
      hold_q   <= hold_d;
      hb_cnt_q <= hb_cnt_d;
      hb_q     <= hb_d;
    end
  end

  assign bus.core_rst_n = run;
  assign bus.btn_db     = db_q[2:0];
  assign bus.heartbeat  = hb_q;
  assign bus.state      = state_q;
  assign bus.ui_in      = run ? {db_q[1], db_q[2],
                                 db_q[1], db_q[2],
                                 1'b0, db_q[0], 1'b0}
                              : 7'h00;
endmodule

// File: tb/tb_board_ctrl_sequencer.sv
// Scoreboard bench for board_ctrl_sequencer:
// stimulus queues timed expectations, monitor checks.
module tb_board_ctrl_sequencer;
  localparam int K_ST = 0;
  localparam int K_CR = 1;
  localparam int K_UI = 2;
  localparam int K_DB = 3;
  localparam int K_HB = 4;

  typedef struct {
    int         cyc;
    int         kind;
    logic [7:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  exp_t sbq[$];

  board_ctrl_sequencer_if bus ();

  board_ctrl_sequencer #(
    .DEBOUNCE_CYCLES  (4),
    .RESET_HOLD_CYCLES(8),
    .HEARTBEAT_CYCLES (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic string kname(int k);
    case (k)
      K_ST:    return "state";
      K_CR:    return "core_rst_n";
      K_UI:    return "ui_in";
      K_DB:    return "btn_db";
      default: return "heartbeat";
    endcase
  endfunction

  function automatic logic [7:0] actual(int k);
    case (k)
      K_ST:    return {6'd0, bus.state};
      K_CR:    return {7'd0, bus.core_rst_n};
      K_UI:    return {1'b0, bus.ui_in};
      K_DB:    return {5'd0, bus.btn_db};
      default: return {7'd0, bus.heartbeat};
    endcase
  endfunction

  function automatic void push(int c, int k,
                               logic [7:0] v);
    exp_t e;
    int   i;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > c) i--;
    sbq.insert(i, e);
  endfunction

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // monitor: compare every expectation due this cycle
  initial forever begin
    exp_t       e;
    logic [7:0] a;
    @(negedge clk);
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      a = actual(e.kind);
      n_tests++;
      if (e.cyc != cyc || a !== e.val) begin
        n_fail++;
        $display("FAIL %s @cyc %0d (now %0d): got %0h want %0h",
                 kname(e.kind), e.cyc, cyc, a, e.val);
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.pll_locked = 1'b0;
    bus.btn_rst_n  = 1'b1;
    bus.btn        = 3'b000;
    tick(2);
    push(cyc, K_ST, 0);
    push(cyc, K_CR, 0);
    push(cyc, K_UI, 0);
    push(cyc, K_DB, 0);
    push(cyc, K_HB, 0);
    rst = 1'b0;
    tick(1);
    // power-up: lock seen after 2 sync edges
    bus.pll_locked = 1'b1;
    push(cyc + 1,  K_ST, 0);
    push(cyc + 2,  K_ST, 0);
    push(cyc + 3,  K_ST, 1);
    push(cyc + 3,  K_CR, 0);
    push(cyc + 10, K_ST, 1);
    push(cyc + 10, K_CR, 0);
    push(cyc + 10, K_UI, 0);
    push(cyc + 11, K_ST, 2);
    push(cyc + 11, K_CR, 1);
    tick(11);
    n_tests++;
    if (bus.state !== 2'd2) begin
      n_fail++;
      $display("FAIL direct: state %0d want 2",
               bus.state);
    end
    n_tests++;
    if (bus.core_rst_n !== 1'b1) begin
      n_fail++;
      $display("FAIL direct: core_rst_n %0b want 1",
               bus.core_rst_n);
    end
    // first RUN cycle: heartbeat and bounce
    push(cyc + 9,  K_HB, 0);
    push(cyc + 10, K_HB, 1);
    push(cyc + 19, K_HB, 1);
    push(cyc + 20, K_HB, 0);
    push(cyc + 29, K_HB, 0);
    push(cyc + 30, K_HB, 1);
    push(cyc + 34, K_HB, 1);
    push(cyc + 10, K_DB, 0);
    push(cyc + 25, K_DB, 0);
    push(cyc + 25, K_UI, 0);
    push(cyc + 26, K_DB, 1);
    push(cyc + 26, K_UI, 8'h02);
    for (int k = 0; k < 10; k++) begin
      bus.btn[0] = (k % 2 == 0);
      tick(2);
    end
    bus.btn[0] = 1'b1;
    tick(15);
    // asynchronous reset after 35 RUN cycles
    rst = 1'b1;
    #1;
    n_tests++;
    if (bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL direct: async state %0d want 0",
               bus.state);
    end
    n_tests++;
    if (bus.heartbeat !== 1'b0) begin
      n_fail++;
      $display("FAIL direct: async heartbeat %0b",
               bus.heartbeat);
    end
    push(cyc, K_ST, 0);
    push(cyc, K_HB, 0);
    push(cyc, K_CR, 0);
    push(cyc, K_UI, 0);
    push(cyc, K_DB, 0);
    push(cyc + 1, K_DB, 0);
    tick(2);
    rst = 1'b0;
    push(cyc + 2,  K_ST, 0);
    push(cyc + 3,  K_ST, 1);
    push(cyc + 5,  K_DB, 0);
    push(cyc + 6,  K_DB, 1);
    push(cyc + 10, K_UI, 0);
    push(cyc + 11, K_ST, 2);
    push(cyc + 11, K_UI, 8'h02);
    tick(13);
    // button reset from RUN
    bus.btn_rst_n = 1'b0;
    push(cyc + 6,  K_ST, 2);
    push(cyc + 7,  K_ST, 1);
    push(cyc + 7,  K_UI, 0);
    push(cyc + 7,  K_CR, 0);
    push(cyc + 10, K_DB, 1);
    push(cyc + 25, K_ST, 1);
    tick(20);
    bus.btn_rst_n = 1'b1;
    push(cyc + 13, K_ST, 1);
    push(cyc + 13, K_CR, 0);
    push(cyc + 14, K_ST, 2);
    push(cyc + 14, K_CR, 1);
    push(cyc + 14, K_UI, 8'h02);
    tick(14);
    push(cyc + 9,  K_HB, 0);
    push(cyc + 10, K_HB, 1);
    tick(8);
    // press lands on the same FSM edge as lock loss
    bus.btn_rst_n = 1'b0;
    tick(4);
    bus.pll_locked = 1'b0;
    push(cyc + 2,  K_ST, 2);
    push(cyc + 3,  K_ST, 0);
    push(cyc + 3,  K_CR, 0);
    push(cyc + 3,  K_UI, 0);
    push(cyc + 3,  K_HB, 1);
    push(cyc + 3,  K_DB, 1);
    push(cyc + 15, K_HB, 1);
    push(cyc + 15, K_ST, 0);
    tick(20);
    n_tests++;
    if (bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL direct: final state %0d want 0",
               bus.state);
    end
    while (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      n_tests++;
      n_fail++;
      $display("FAIL %s @cyc %0d: never checked, want %0h",
               kname(e.kind), e.cyc, e.val);
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end
endmodule
